// File: rtl/c4_cmd_pkg.sv
// Shared encodings for the connect-four input sequencer: queued command codes,
// issue FSM states and button lane indices.
package c4_cmd_pkg;
  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_LEFT  = 2'b01,
    CMD_RIGHT = 2'b10,
    CMD_DROP  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    GAP   = 2'b10
  } state_e;

  localparam int NUM_BTN   = 3;
  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DROP  = 2;
endpackage

// File: rtl/c4_input_sequencer_if.sv
// Engine-side bundle: ready/game-over in, command pulses and queue status out.
interface c4_input_sequencer_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int QC_W = $clog2(FIFO_DEPTH) + 1;

  logic            game_ready;
  logic            game_over;
  logic            cmd_right;
  logic            cmd_left;
  logic            cmd_drop;
  logic [QC_W-1:0] queue_count;
  logic            overflow;

  modport master (
    input  game_ready, game_over,
    output cmd_right, cmd_left, cmd_drop, queue_count, overflow
  );

  modport slave (
    output game_ready, game_over,
    input  cmd_right, cmd_left, cmd_drop, queue_count, overflow
  );
endinterface

// File: rtl/c4_input_sequencer_debouncer.sv
// Per-button lane: two-flop synchronizer, saturating-free debounce counter and
// a single-cycle rise strobe on the debounced level.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clk_25MHz,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);
  logic [1:0]       sync;
  logic             deb, deb_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      deb   <= 1'b0;
      deb_d <= 1'b0;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], btn};
      deb_d <= deb;
      if (sync[1] == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = deb & ~deb_d;
endmodule

// File: rtl/c4_input_sequencer.sv
// Button front-end for the connect-four engine: debounced presses are latched as
// pending, serialized into a small FIFO and issued as rate-limited pulses.
module c4_input_sequencer
  import c4_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 2
) (
  input  logic                  clk_25MHz,
  input  logic                  rst_n,
  input  logic                  move_right,
  input  logic                  move_left,
  input  logic                  drop_piece,
  c4_input_sequencer_if.master  bus
);
  localparam int QC_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  logic [NUM_BTN-1:0] btn_raw, rise, pend, pend_clr, lost;
  logic               push, pop, can_issue, overflow_q;
  cmd_e               push_cmd, cmd_q;
  cmd_e               fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [QC_W-1:0]    count;
  state_e             state, state_nxt;
  logic [GAP_W-1:0]   gap_cnt;

  assign btn_raw = {drop_piece, move_left, move_right};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk_25MHz(clk_25MHz),
      .rst_n    (rst_n),
      .btn      (btn_raw[i]),
      .rise     (rise[i])
    );
  end

  // A rise only counts as lost if the flag stays set this cycle; a same-cycle push frees it.
  assign lost = rise & pend & ~pend_clr;

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= '0;
      overflow_q <= 1'b0;
    end else if (bus.game_over) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~pend_clr) | rise;
      if (|lost) overflow_q <= 1'b1;
    end
  end

  always_comb begin
    push     = 1'b0;
    push_cmd = CMD_NONE;
    pend_clr = '0;
    if (!bus.game_over && count != QC_W'(FIFO_DEPTH)) begin
      if (pend[BTN_DROP]) begin
        push = 1'b1; push_cmd = CMD_DROP;  pend_clr[BTN_DROP]  = 1'b1;
      end else if (pend[BTN_LEFT]) begin
        push = 1'b1; push_cmd = CMD_LEFT;  pend_clr[BTN_LEFT]  = 1'b1;
      end else if (pend[BTN_RIGHT]) begin
        push = 1'b1; push_cmd = CMD_RIGHT; pend_clr[BTN_RIGHT] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (push) fifo_mem[wr_ptr] <= push_cmd;
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.game_over) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + QC_W'(push) - QC_W'(pop);
    end
  end

  assign can_issue = (count != '0) && bus.game_ready && !bus.game_over;

  // The last GAP cycle decides like IDLE so queued commands go out every 1+GAP cycles.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      IDLE:  if (can_issue) begin state_nxt = ISSUE; pop = 1'b1; end
      ISSUE: state_nxt = GAP;
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          if (can_issue) begin state_nxt = ISSUE; pop = 1'b1; end
          else           state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
      cmd_q   <= CMD_NONE;
    end else begin
      state   <= state_nxt;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      cmd_q   <= pop ? fifo_mem[rd_ptr] : CMD_NONE;
    end
  end

  assign bus.cmd_right   = (cmd_q == CMD_RIGHT);
  assign bus.cmd_left    = (cmd_q == CMD_LEFT);
  assign bus.cmd_drop    = (cmd_q == CMD_DROP);
  assign bus.queue_count = count;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_c4_input_sequencer.sv
// Directed bench for c4_input_sequencer with D=4, GAP=2, FIFO depth 4.
module tb_c4_input_sequencer;
  logic       clk_25MHz = 1'b0;
  logic       rst_n     = 1'b0;
  logic [2:0] btns      = 3'b000;  // {drop, left, right}
  int         total = 0, fails = 0, cyc = 0;
  logic [2:0] log_code [$];
  int         log_cyc  [$];
  logic [2:0] qc_h [12];
  logic       cl_h [12];
  int         cyc0;
  logic       got, seen;

  c4_input_sequencer_if #(.FIFO_DEPTH(4)) bus ();

  c4_input_sequencer #(
    .DEBOUNCE_CYCLES(4), .CNT_W(3), .FIFO_DEPTH(4), .GAP_CYCLES(2)
  ) dut (
    .clk_25MHz (clk_25MHz),
    .rst_n     (rst_n),
    .move_right(btns[0]),
    .move_left (btns[1]),
    .drop_piece(btns[2]),
    .bus       (bus)
  );

  always #5 clk_25MHz = ~clk_25MHz;
  always @(posedge clk_25MHz) cyc <= cyc + 1;

  always @(negedge clk_25MHz)
    if (bus.cmd_right | bus.cmd_left | bus.cmd_drop) begin
      log_code.push_back({bus.cmd_drop, bus.cmd_left, bus.cmd_right});
      log_cyc.push_back(cyc);
    end

  task automatic tick();
    @(posedge clk_25MHz); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] code_at(input int i);
    return (log_code.size() > i) ? log_code[i] : 3'b111;
  endfunction

  function automatic int cyc_at(input int i);
    return (log_cyc.size() > i) ? log_cyc[i] : -1000;
  endfunction

  task automatic reset_dut();
    rst_n = 1'b0; btns = 3'b000; bus.game_ready = 1'b0; bus.game_over = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    log_code.delete(); log_cyc.delete();
  endtask

  task automatic press(input int b);
    btns[b] = 1'b1; repeat (10) tick();
    btns[b] = 1'b0; repeat (12) tick();
  endtask

  initial begin
    bus.game_ready = 1'b0; bus.game_over = 1'b0;
    #1;
    chk("in_reset", {bus.cmd_drop, bus.cmd_left, bus.cmd_right, bus.overflow, bus.queue_count}, 0);
    reset_dut();
    chk("after_reset", {bus.cmd_drop, bus.cmd_left, bus.cmd_right, bus.overflow, bus.queue_count}, 0);

    // single press: edge 0 is the tick where the button rises
    bus.game_ready = 1'b1; btns = 3'b010;
    for (int k = 1; k <= 11; k++) begin tick(); qc_h[k] = bus.queue_count; cl_h[k] = bus.cmd_left; end
    chk("single_qc_e7",  qc_h[7], 0);
    chk("single_qc_e8",  qc_h[8], 1);
    chk("single_qc_e9",  qc_h[9], 0);
    chk("single_cmd_e8", cl_h[8], 0);
    chk("single_cmd_e9", cl_h[9], 1);
    chk("single_cmd_e10", cl_h[10], 0);
    btns = 3'b000; repeat (12) tick();
    chk("single_count", log_code.size(), 1);

    // glitch shorter than D
    reset_dut(); bus.game_ready = 1'b1;
    btns = 3'b100; repeat (3) tick(); btns = 3'b000;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin tick(); if (bus.queue_count != 0) seen = 1'b1; end
    chk("glitch_qc", seen, 0);
    chk("glitch_cmds", log_code.size(), 0);

    // simultaneous press
    reset_dut(); bus.game_ready = 1'b1;
    cyc0 = cyc; btns = 3'b111;
    repeat (12) tick(); btns = 3'b000; repeat (20) tick();
    chk("simul_count", log_code.size(), 3);
    chk("simul_0", code_at(0), 3'b100);
    chk("simul_1", code_at(1), 3'b010);
    chk("simul_2", code_at(2), 3'b001);
    chk("simul_t0", cyc_at(0) - cyc0, 9);
    chk("simul_gap1", cyc_at(1) - cyc_at(0), 3);
    chk("simul_gap2", cyc_at(2) - cyc_at(1), 3);
    chk("simul_ovf", bus.overflow, 0);

    // backpressure and overflow
    reset_dut();
    press(0); press(0); press(0); press(1);
    chk("bp_full", bus.queue_count, 4);
    press(0);
    chk("bp_full2", bus.queue_count, 4);
    chk("bp_no_ovf", bus.overflow, 0);
    press(0);
    chk("bp_ovf", bus.overflow, 1);
    chk("bp_nocmd", log_code.size(), 0);
    bus.game_ready = 1'b1; repeat (30) tick();
    chk("bp_drain_n", log_code.size(), 5);
    chk("bp_d0", code_at(0), 3'b001);
    chk("bp_d1", code_at(1), 3'b001);
    chk("bp_d2", code_at(2), 3'b001);
    chk("bp_d3", code_at(3), 3'b010);
    chk("bp_d4", code_at(4), 3'b001);
    chk("bp_empty", bus.queue_count, 0);
    chk("bp_ovf_sticky", bus.overflow, 1);

    // game over flush
    reset_dut();
    press(0); press(1); press(2);
    chk("go_q3", bus.queue_count, 3);
    bus.game_over = 1'b1; tick();
    chk("go_flush", bus.queue_count, 0);
    bus.game_ready = 1'b1;
    press(0); press(0); press(1);
    chk("go_ovf", bus.overflow, 0);
    chk("go_qc", bus.queue_count, 0);
    bus.game_over = 1'b0; repeat (20) tick();
    chk("go_nocmd", log_code.size(), 0);
    chk("go_qc_after", bus.queue_count, 0);

    // reset during ISSUE
    reset_dut();
    press(0); press(1);
    chk("rst_q2", bus.queue_count, 2);
    bus.game_ready = 1'b1; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin tick(); if (bus.cmd_right) got = 1'b1; end
    chk("rst_wait_issue", got, 1);
    chk("rst_qc_issue", bus.queue_count, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cmd_async", {bus.cmd_drop, bus.cmd_left, bus.cmd_right}, 0);
    chk("rst_qc_async", bus.queue_count, 0);
    tick(); tick(); rst_n = 1'b1;
    log_code.delete(); log_cyc.delete();
    repeat (25) tick();
    chk("rst_nothing_after", log_code.size(), 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/c4_input_sequencer.md
# c4_input_sequencer

Front-end controller that turns the three raw push-button inputs (right, left, drop) into clean, rate-limited, single-cycle game commands for the connect-four game engine. Each button is synchronized, debounced and edge-detected. Press events are serialized into a small command FIFO and issued one at a time, only when the engine reports ready and no winner exists. It sits between the board-level button pins and the game engine's `move_right` / `move_left` / `drop_piece` inputs.

## Interface
- `DEBOUNCE_CYCLES`, 250000: consecutive cycles a synchronized level must differ from the debounced level before it is accepted (10 ms at 25 MHz); minimum 2.
- `CNT_W`, 18: debounce counter width; must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.
- `FIFO_DEPTH`, 4: command queue entries; power of two.
- `GAP_CYCLES`, 2: idle cycles enforced after each issued command; minimum 1.

Ports:
- `clk_25MHz`  in  1  pixel/system clock, single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `move_right`  in  1  raw button, asynchronous to the clock.
- `move_left`  in  1  raw button, asynchronous.
- `drop_piece`  in  1  raw button, asynchronous.
- `game_ready`  in  1  engine can accept a command this cycle.
- `game_over`  in  1  high while a winner is latched (winner ≠ 0).
- `cmd_right`  out  1  one-cycle pulse to the engine.
- `cmd_left`  out  1  one-cycle pulse.
- `cmd_drop`  out  1  one-cycle pulse.
- `queue_count`  out  $clog2(FIFO_DEPTH)+1  entries currently queued.
- `overflow`  out  1  sticky; set when a press event is lost.

## Operation
- Reset values: all `cmd_*` = 0, `queue_count` = 0, `overflow` = 0. Synchronizers, debounced levels, counters and pending flags are cleared; FSM is in IDLE. Reset asserted mid-operation discards queued and in-flight commands immediately.
- Synchronizer: two flops per button.
- Debouncer (per button):
  - Counter clears whenever the synchronized level equals the debounced level; otherwise it increments.
  - On a differing cycle where counter = DEBOUNCE_CYCLES−1, the debounced level takes the synchronized value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is ignored.
- Event: a 0→1 transition of the debounced level. Releases produce no event.
- Pending flags: one per button, set on the cycle after that button's event.
  - An event on a button whose pending flag is already set is lost and sets `overflow`.
- Push: at most one push per cycle, and only when the FIFO is not full. Priority is drop > left > right. The pushed flag clears.
- FIFO entry encoding: LEFT = 2'b01, RIGHT = 2'b10, DROP = 2'b11. A push and a pop in the same cycle are legal; the count is unchanged.
- Issue FSM:
  - IDLE → ISSUE when FIFO is non-empty, `game_ready` = 1 and `game_over` = 0. Pops the head and registers the matching `cmd_*`.
  - ISSUE → GAP after exactly one cycle. `cmd_*` is high only in ISSUE.
  - GAP holds GAP_CYCLES cycles, then → IDLE.
- `game_over` = 1 has these effects:
  - FIFO is flushed to 0 and all pending flags are cleared.
  - New events are ignored and do not set `overflow`.
  - No new issue occurs. A pulse already in ISSUE completes.
- `overflow` clears only on reset.

## Timing
- The raw button is high and stable before edge 0. The synchronized level goes high at edge 2 and the debounced level at edge 2+D (D = DEBOUNCE_CYCLES).
- Pending is set at edge 3+D and the push happens at edge 4+D, giving `queue_count` = 1.
- With `game_ready` = 1, the pop happens at edge 5+D. `cmd_*` is high from edge 5+D to edge 6+D.
- Back-to-back queued commands are issued every 1+GAP_CYCLES cycles.
- `game_ready` low stalls in IDLE indefinitely with no loss.

## Structure
- Package `c4_cmd_pkg`: command encodings (LEFT, RIGHT, DROP), FSM state enum (IDLE, ISSUE, GAP).
- Sub-module `button_debouncer`: synchronizer, debounce counter and rise-event output. Instantiated three times.
- FIFO is inline: pointer-based, with `queue_count` register.

## Test plan
All scenarios use D = 4 and GAP = 2.
- Single press: `move_left` held high → `cmd_left` high for exactly one cycle, edge 9 to edge 10. `queue_count` goes 0→1→0.
- Glitch: `drop_piece` high for 3 cycles, then low → no `cmd_*` and `queue_count` stays 0.
- Simultaneous press: all three buttons rise together → issue order is drop, left, right. Pulses are 3 cycles apart. `overflow` = 0.
- Backpressure and overflow: `game_ready` = 0 while 5 separate right presses plus 1 left press arrive → `queue_count` saturates at 4. One right press is left pending and the next right press sets `overflow`. Raising `game_ready` drains the queue in FIFO order.
- Game over: 3 commands queued, then `game_over` asserted → `queue_count` = 0 next cycle. Further presses give no `cmd_*` and `overflow` stays 0.
- Reset mid-issue: `rst_n` low during ISSUE → `cmd_*` = 0 and `queue_count` = 0 immediately (asynchronous). No command follows after release.
